// File: rtl/modulador_seq.sv
// rtl/modulador_seq.sv - multi-cycle restoring remainder unit with start/done handshake
// Optional feature macro: MODULADOR_QUOTIENT_EN adds the quot_o port and its result register.
// Zero dividend or zero divisor takes a one-cycle fast path that returns 0.

module modulador_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] result_o
`ifdef MODULADOR_QUOTIENT_EN
  ,
  output logic [WIDTH-1:0] quot_o
`endif
);

  // Counter is one bit wider than needed for WIDTH-1 so it can hold WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Dividend shift register: dividend bits leave at the top, quotient bits enter at the bottom.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             zero_op;
  logic             last_iter;
  logic [WIDTH:0]   rem_shift;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;

  assign accept    = (state_q == S_IDLE) && start_i;
  assign zero_op   = (data0_i == '0) || (data1_i == '0);
  assign last_iter = (cnt_q == LAST_ITER);

  // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
  // Both the difference and the kept value are below 2^WIDTH, so the low WIDTH bits are exact.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    no_borrow = (rem_shift >= {1'b0, dsr_q});
    rem_next  = no_borrow ? (rem_shift[WIDTH-1:0] - dsr_q) : rem_shift[WIDTH-1:0];
    quot_next = {dvd_q[WIDTH-2:0], no_borrow};
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: zero operands skip RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = zero_op ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; busy covers accept through the done cycle.
  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  // Iteration datapath: operands latched at accept, one quotient bit per RUN cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      dvd_q <= data0_i;
      dsr_q <= data1_i;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      dvd_q <= quot_next;
      rem_q <= rem_next;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Visible remainder and divide-by-zero flag change only when DONE is entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o <= '0;
      div0_o   <= 1'b0;
    end else if (accept && zero_op) begin
      result_o <= '0;
      div0_o   <= (data1_i == '0);
    end else if ((state_q == S_RUN) && last_iter) begin
      result_o <= rem_next;
      div0_o   <= 1'b0;
    end
  end

`ifdef MODULADOR_QUOTIENT_EN
  // Visible quotient, captured on the same DONE entry as the remainder.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quot_o <= '0;
    end else if (accept && zero_op) begin
      quot_o <= '0;
    end else if ((state_q == S_RUN) && last_iter) begin
      quot_o <= quot_next;
    end
  end
`endif

endmodule
